// File: rtl/writeback_regfile.sv
// writeback_regfile -- Y86-64 write-back stage.
//
// Captures the memory-stage outputs (m_*) into the W pipeline register,
// commits W_valE / W_valM to the 15-entry register file, and serves the two
// combinational decode read ports. It also exports the W fields used by
// forwarding, the processor status, a sticky halt flag and a retire counter.
//
// Ports
//   clk, rst_n            rising-edge clock, async active-low reset
//   m_stat/icode/valE/valM/dstE/dstM   instruction leaving data_memory
//   W_stall, W_bubble     W register hold / NOP-insert controls (stall wins)
//   d_srcA, d_srcB        decode read addresses (15 = RNONE reads 0)
//   d_rvalA, d_rvalB      decode read data
//   W_icode/dstE/dstM/valE/valM        W register contents
//   Stat                  W_stat; a bubble reports SAOK
//   halted                sticky, set the edge after an exception reaches W
//   retire_cnt            SAOK instructions that have left W (wraps)
//
// Configuration
//   WB_BYPASS_EN  when defined, a read whose address matches the register
//                 being committed this cycle returns the committing value
//                 (valM over valE). When undefined, reads return the
//                 contents before the edge, and the pipeline forwarding
//                 logic resolves that hazard.
module writeback_regfile #(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] RSP_INIT = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        m_dstE,
  input  logic [3:0]        m_dstM,
  input  logic              W_stall,
  input  logic              W_bubble,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] d_rvalA,
  output logic [DATA_W-1:0] d_rvalB,
  output logic [3:0]        W_icode,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [2:0]        Stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [2:0] SADR  = 3'd2;
  localparam logic [2:0] SINS  = 3'd3;
  localparam logic [2:0] SHLT  = 3'd4;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;
  localparam int         NREGS = 15;

  typedef struct packed {
    logic              valid;
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{valid: 1'b0, stat: SAOK, icode: INOP,
                                  valE: '0, valM: '0, dstE: RNONE, dstM: RNONE};

  w_reg_t            w_q;
  logic [DATA_W-1:0] regs [NREGS];

  logic w_exc;
  logic commit;
  logic w_hold;
  logic retire;

  assign w_exc  = (w_q.stat == SADR) || (w_q.stat == SINS) || (w_q.stat == SHLT);
  assign commit = (w_q.stat == SAOK) && !halted;
  // An excepting instruction freezes W as soon as it arrives, so Stat keeps
  // reporting the fault after halted rises.
  assign w_hold = halted || W_stall || w_exc;
  assign retire = w_q.valid && commit && !W_stall;

  // W pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= W_BUBBLE;
    end else if (w_hold) begin
      w_q <= w_q;
    end else if (W_bubble) begin
      w_q <= W_BUBBLE;
    end else begin
      w_q <= '{valid: 1'b1, stat: m_stat, icode: m_icode, valE: m_valE,
               valM: m_valM, dstE: m_dstE, dstM: m_dstM};
    end
  end

  // Register file. A stalled SAOK instruction rewrites the same values each
  // cycle, which is harmless. When dstE == dstM (popq %rsp), valM wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == 4) ? RSP_INIT : '0;
    end else if (commit) begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_q.dstM == 4'(i))      regs[i] <= w_q.valM;
        else if (w_q.dstE == 4'(i)) regs[i] <= w_q.valE;
      end
    end
  end

  // Sticky halt and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (w_exc) halted <= 1'b1;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Read ports. RNONE never matches an entry in the loop, so it reads 0.
  logic [DATA_W-1:0] file_a, file_b;

  always_comb begin
    file_a = '0;
    file_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (d_srcA == 4'(i)) file_a = regs[i];
      if (d_srcB == 4'(i)) file_b = regs[i];
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    d_rvalA = file_a;
    if (commit && (w_q.dstM != RNONE) && (d_srcA == w_q.dstM))      d_rvalA = w_q.valM;
    else if (commit && (w_q.dstE != RNONE) && (d_srcA == w_q.dstE)) d_rvalA = w_q.valE;
  end

  always_comb begin
    d_rvalB = file_b;
    if (commit && (w_q.dstM != RNONE) && (d_srcB == w_q.dstM))      d_rvalB = w_q.valM;
    else if (commit && (w_q.dstE != RNONE) && (d_srcB == w_q.dstE)) d_rvalB = w_q.valE;
  end
`else
  assign d_rvalA = file_a;
  assign d_rvalB = file_b;
`endif

  assign W_icode = w_q.icode;
  assign W_dstE  = w_q.dstE;
  assign W_dstM  = w_q.dstM;
  assign W_valE  = w_q.valE;
  assign W_valM  = w_q.valM;
  assign Stat    = w_q.stat;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  m_stat = 3'd1;
  logic [3:0]  m_icode = 4'h1;
  logic [63:0] m_valE = '0, m_valM = '0;
  logic [3:0]  m_dstE = 4'hF, m_dstM = 4'hF;
  logic        W_stall = 1'b0, W_bubble = 1'b1;
  logic [3:0]  d_srcA = 4'd4, d_srcB = 4'd0;
  logic [63:0] d_rvalA, d_rvalB, W_valE, W_valM;
  logic [3:0]  W_icode, W_dstE, W_dstM;
  logic [2:0]  Stat;
  logic        halted;
  logic [31:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  writeback_regfile #(.DATA_W(64), .RSP_INIT(64'h1000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM),
    .Stat(Stat), .halted(halted), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    m_stat = st; m_icode = ic; m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; W_bubble = 1'b1; d_srcA = 4'd4; d_srcB = 4'd0;
    #12;
    checks++; if (d_rvalA !== 64'h1000) begin errors++; $display("FAIL reset_reg4: got %h expected %h", d_rvalA, 64'h1000); end
    checks++; if (d_rvalB !== 64'h0) begin errors++; $display("FAIL reset_reg0: got %h expected 0", d_rvalB); end
    checks++; if (W_icode !== 4'h1) begin errors++; $display("FAIL reset_W_icode: got %h expected 1", W_icode); end
    checks++; if (W_dstE !== 4'hF || W_dstM !== 4'hF) begin errors++; $display("FAIL reset_W_dst: got %h/%h expected f/f", W_dstE, W_dstM); end
    checks++; if (Stat !== 3'd1) begin errors++; $display("FAIL reset_Stat: got %0d expected 1", Stat); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire: got %0d expected 0", retire_cnt); end
    d_srcA = 4'hF;
    #1;
    checks++; if (d_rvalA !== 64'h0) begin errors++; $display("FAIL reset_rnone_read: got %h expected 0", d_rvalA); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_commit();
    set_m(3'd1, 4'h3, 4'd2, 64'h5, 4'hF, 64'h0);
    W_bubble = 1'b0; d_srcA = 4'd2;
    step();
    checks++; if (W_icode !== 4'h3 || W_dstE !== 4'd2 || W_valE !== 64'h5) begin errors++; $display("FAIL alu_W_load: got icode %h dstE %h valE %h expected 3 2 5", W_icode, W_dstE, W_valE); end
    W_bubble = 1'b1;
    step();
    checks++; if (d_rvalA !== 64'h5) begin errors++; $display("FAIL alu_reg2: got %h expected 5", d_rvalA); end
    checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL alu_retire: got %0d expected 1", retire_cnt); end
    checks++; if (W_icode !== 4'h1) begin errors++; $display("FAIL alu_bubble_icode: got %h expected 1", W_icode); end
  endtask

  task automatic test_popq_and_dual();
    set_m(3'd1, 4'hB, 4'd4, 64'h10, 4'd4, 64'h55);
    W_bubble = 1'b0; d_srcA = 4'd4;
    step();
    W_bubble = 1'b1;
    step();
    checks++; if (d_rvalA !== 64'h55) begin errors++; $display("FAIL popq_rsp: got %h expected 55", d_rvalA); end
    checks++; if (retire_cnt !== 32'd2) begin errors++; $display("FAIL popq_retire: got %0d expected 2", retire_cnt); end
    set_m(3'd1, 4'hB, 4'd1, 64'h11, 4'd6, 64'h66);
    W_bubble = 1'b0; d_srcA = 4'd1; d_srcB = 4'd6;
    step();
    W_bubble = 1'b1;
    step();
    checks++; if (d_rvalA !== 64'h11) begin errors++; $display("FAIL dual_reg1: got %h expected 11", d_rvalA); end
    checks++; if (d_rvalB !== 64'h66) begin errors++; $display("FAIL dual_reg6: got %h expected 66", d_rvalB); end
    checks++; if (retire_cnt !== 32'd3) begin errors++; $display("FAIL dual_retire: got %0d expected 3", retire_cnt); end
  endtask

  task automatic test_bypass();
    logic [63:0] exp_same;
`ifdef WB_BYPASS_EN
    exp_same = 64'h77;
`else
    exp_same = 64'h0;
`endif
    set_m(3'd1, 4'h6, 4'd3, 64'h77, 4'hF, 64'h0);
    W_bubble = 1'b0; d_srcB = 4'd3;
    step();
    checks++; if (d_rvalB !== exp_same) begin errors++; $display("FAIL bypass_same_cycle: got %h expected %h", d_rvalB, exp_same); end
    W_bubble = 1'b1;
    step();
    checks++; if (d_rvalB !== 64'h77) begin errors++; $display("FAIL bypass_after_commit: got %h expected 77", d_rvalB); end
    checks++; if (retire_cnt !== 32'd4) begin errors++; $display("FAIL bypass_retire: got %0d expected 4", retire_cnt); end
  endtask

  task automatic test_stall();
    set_m(3'd1, 4'h2, 4'd5, 64'h99, 4'hF, 64'h0);
    W_bubble = 1'b0; W_stall = 1'b0; d_srcA = 4'd5; d_srcB = 4'd8;
    step();
    set_m(3'd1, 4'h7, 4'd8, 64'h1234, 4'hF, 64'h0);
    W_stall = 1'b1; W_bubble = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (W_icode !== 4'h2 || W_dstE !== 4'd5 || W_valE !== 64'h99) begin errors++; $display("FAIL stall_hold_W c%0d: got icode %h dstE %h valE %h expected 2 5 99", c, W_icode, W_dstE, W_valE); end
      checks++; if (retire_cnt !== 32'd4) begin errors++; $display("FAIL stall_retire c%0d: got %0d expected 4", c, retire_cnt); end
      checks++; if (d_rvalA !== 64'h99) begin errors++; $display("FAIL stall_reg5 c%0d: got %h expected 99", c, d_rvalA); end
    end
    checks++; if (d_rvalB !== 64'h0) begin errors++; $display("FAIL stall_reg8: got %h expected 0", d_rvalB); end
    W_stall = 1'b0;
    step();
    checks++; if (W_icode !== 4'h1) begin errors++; $display("FAIL stall_release_bubble: got %h expected 1", W_icode); end
    checks++; if (retire_cnt !== 32'd5) begin errors++; $display("FAIL stall_release_retire: got %0d expected 5", retire_cnt); end
  endtask

  task automatic test_exception();
    set_m(3'd2, 4'h5, 4'hF, 64'h0, 4'd0, 64'hAA);
    W_bubble = 1'b0; d_srcA = 4'd0;
    step();
    checks++; if (Stat !== 3'd2 || halted !== 1'b0) begin errors++; $display("FAIL exc_arrive: got Stat %0d halted %b expected 2 0", Stat, halted); end
    set_m(3'd1, 4'h3, 4'd0, 64'h33, 4'hF, 64'h0);
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL exc_halted: got %b expected 1", halted); end
    checks++; if (Stat !== 3'd2) begin errors++; $display("FAIL exc_Stat: got %0d expected 2", Stat); end
    repeat (3) step();
    checks++; if (d_rvalA !== 64'h0) begin errors++; $display("FAIL exc_reg0: got %h expected 0", d_rvalA); end
    checks++; if (retire_cnt !== 32'd5) begin errors++; $display("FAIL exc_retire_frozen: got %0d expected 5", retire_cnt); end
    checks++; if (W_icode !== 4'h5 || Stat !== 3'd2) begin errors++; $display("FAIL exc_W_frozen: got icode %h Stat %0d expected 5 2", W_icode, Stat); end
  endtask

  task automatic test_reset_midrun();
    #2;
    rst_n = 1'b0; d_srcA = 4'd5; d_srcB = 4'd4;
    #1;
    checks++; if (halted !== 1'b0 || retire_cnt !== 32'd0) begin errors++; $display("FAIL mid_reset_state: got halted %b retire %0d expected 0 0", halted, retire_cnt); end
    checks++; if (W_icode !== 4'h1 || Stat !== 3'd1) begin errors++; $display("FAIL mid_reset_W: got icode %h Stat %0d expected 1 1", W_icode, Stat); end
    checks++; if (d_rvalA !== 64'h0 || d_rvalB !== 64'h1000) begin errors++; $display("FAIL mid_reset_regs: got %h/%h expected 0/1000", d_rvalA, d_rvalB); end
    set_m(3'd1, 4'h3, 4'd7, 64'h42, 4'hF, 64'h0);
    W_bubble = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    W_bubble = 1'b0; d_srcA = 4'd7;
    step();
    W_bubble = 1'b1;
    step();
    checks++; if (d_rvalA !== 64'h42 || retire_cnt !== 32'd1) begin errors++; $display("FAIL post_reset_commit: got %h cnt %0d expected 42 1", d_rvalA, retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu_commit();
    test_popq_and_dual();
    test_bypass();
    test_stall();
    test_exception();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
